// File: rtl/coin_credit_acceptor_if.sv
// Bundle of coin/button inputs, downstream feedback and commit/refund outputs
// shared between the coin credit acceptor and whoever drives or observes it.
interface coin_credit_acceptor_if;
  logic       coin1;
  logic       coin5;
  logic       coin10;
  logic       confirm;
  logic       cancel;
  logic [9:0] remain;
  logic [9:0] money;
  logic       set;
  logic [9:0] refund;
  logic       refund_valid;
  logic [9:0] pending;
  logic       coin_reject;
  logic [1:0] state;

  modport slave (
    input  coin1, coin5, coin10, confirm, cancel, remain,
    output money, set, refund, refund_valid, pending, coin_reject, state
  );

  modport master (
    output coin1, coin5, coin10, confirm, cancel, remain,
    input  money, set, refund, refund_valid, pending, coin_reject, state
  );
endinterface

// File: rtl/coin_credit_acceptor.sv
// Coin credit acceptor: collects coins into pending credit, commits or refunds it.
// Optional macro BONUS_CREDIT_EN adds BONUS_AMT units at commit when pending >= BONUS_THRESH.
module coin_credit_acceptor #(
  parameter int MAX_CREDIT   = 500,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int DEB_CYC      = 4,
  parameter int BONUS_THRESH = 50,
  parameter int BONUS_AMT    = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  coin_credit_acceptor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = $clog2(DEB_CYC + 1);

  generate
    if (MAX_CREDIT > 1023 || MAX_CREDIT < 1) begin : g_max_check
      $error("MAX_CREDIT must be in 1..1023");
    end
  endgenerate

  // Bit order: {cancel, confirm, coin10, coin5, coin1}
  logic [4:0] raw;
  logic [4:0] sync1_reg;
  logic [4:0] sync2_reg;
  logic [2:0] coin_prev_reg;
  logic [2:0] coin_evt;
  logic [1:0] press;

  assign raw = {bus.cancel, bus.confirm, bus.coin10, bus.coin5, bus.coin1};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= raw[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end

    for (gi = 0; gi < 3; gi++) begin : g_coin_edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coin_prev_reg[gi] <= 1'b0;
        else        coin_prev_reg[gi] <= sync2_reg[gi];
      end
      assign coin_evt[gi] = sync2_reg[gi] & ~coin_prev_reg[gi];
    end

    // One press pulse after DEB_CYC stable-high cycles; re-armed only by a low level.
    for (gi = 0; gi < 2; gi++) begin : g_button
      logic [CW-1:0] cnt_reg;
      logic          armed_reg;
      logic          press_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          armed_reg <= 1'b1;
          press_reg <= 1'b0;
        end else if (!sync2_reg[3+gi]) begin
          cnt_reg   <= '0;
          armed_reg <= 1'b1;
          press_reg <= 1'b0;
        end else if (armed_reg && cnt_reg == CW'(DEB_CYC - 1)) begin
          cnt_reg   <= '0;
          armed_reg <= 1'b0;
          press_reg <= 1'b1;
        end else begin
          if (armed_reg) cnt_reg <= cnt_reg + CW'(1);
          press_reg <= 1'b0;
        end
      end
      assign press[gi] = press_reg;
    end
  endgenerate

  logic confirm_press;
  logic cancel_press;
  assign confirm_press = press[0];
  assign cancel_press  = press[1];

  state_t        state_reg, state_next;
  logic [9:0]    pending_reg, pending_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [9:0]    money_reg, money_next;
  logic          set_reg, set_next;
  logic [9:0]    refund_reg, refund_next;
  logic          refund_valid_reg, refund_valid_next;
  logic          reject_reg, reject_next;

  logic [10:0] sum;
  logic [10:0] total;
  logic        any_coin;
  logic        accept;
  logic [10:0] space;
  logic [10:0] credit;
  logic [9:0]  money_amt;
  logic [9:0]  over;

  assign sum      = (coin_evt[0] ? 11'd1 : 11'd0) + (coin_evt[1] ? 11'd5 : 11'd0)
                  + (coin_evt[2] ? 11'd10 : 11'd0);
  assign total    = {1'b0, pending_reg} + sum;
  assign any_coin = |coin_evt;
  assign accept   = any_coin && (total <= 11'(MAX_CREDIT))
                  && (state_reg == IDLE || state_reg == COLLECT);

  assign space = 11'd1023 - {1'b0, bus.remain};

`ifdef BONUS_CREDIT_EN
  assign credit = ({1'b0, pending_reg} >= 11'(BONUS_THRESH))
                ? {1'b0, pending_reg} + 11'(BONUS_AMT) : {1'b0, pending_reg};
`else
  assign credit = {1'b0, pending_reg};
  generate
    if (BONUS_THRESH < 0 || BONUS_AMT < 0) begin : g_bonus_check
      $error("bonus parameters must be non-negative");
    end
  endgenerate
`endif

  // Bonus units only ever land in money; the refund is based on real coins alone.
  assign money_amt = (credit <= space) ? credit[9:0] : space[9:0];
  assign over      = ({1'b0, pending_reg} > space) ? (pending_reg - space[9:0]) : 10'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      pending_reg      <= '0;
      timer_reg        <= '0;
      money_reg        <= '0;
      set_reg          <= 1'b0;
      refund_reg       <= '0;
      refund_valid_reg <= 1'b0;
      reject_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pending_reg      <= pending_next;
      timer_reg        <= timer_next;
      money_reg        <= money_next;
      set_reg          <= set_next;
      refund_reg       <= refund_next;
      refund_valid_reg <= refund_valid_next;
      reject_reg       <= reject_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    pending_next      = pending_reg;
    timer_next        = timer_reg;
    money_next        = '0;
    set_next          = 1'b0;
    refund_next       = '0;
    refund_valid_next = 1'b0;
    reject_next       = any_coin && !accept;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          pending_next = total[9:0];
          timer_next   = '0;
          state_next   = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          pending_next = total[9:0];
          timer_next   = '0;
        end else begin
          timer_next   = timer_reg + TW'(1);
        end
        if (cancel_press)
          state_next = REFUND;
        else if (confirm_press || (!accept && timer_reg == TW'(TIMEOUT_CYC - 1)))
          state_next = COMMIT;
      end
      COMMIT: begin
        money_next        = money_amt;
        set_next          = (money_amt != 10'd0);
        refund_next       = over;
        refund_valid_next = (over != 10'd0);
        pending_next      = '0;
        state_next        = IDLE;
      end
      REFUND: begin
        refund_next       = pending_reg;
        refund_valid_next = 1'b1;
        pending_next      = '0;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.money        = money_reg;
  assign bus.set          = set_reg;
  assign bus.refund       = refund_reg;
  assign bus.refund_valid = refund_valid_reg;
  assign bus.pending      = pending_reg;
  assign bus.coin_reject  = reject_reg;
  assign bus.state        = state_reg;

endmodule

// File: tb/tb_coin_credit_acceptor.sv
// Scoreboard bench for coin_credit_acceptor: stimulus pushes expected strobes,
// a negedge monitor pops and compares whenever set/refund_valid/coin_reject fires.
module tb_coin_credit_acceptor;

  localparam int T = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coin_credit_acceptor_if bus();

  coin_credit_acceptor #(.TIMEOUT_CYC(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int money;
    int set;
    int refund;
    int refund_valid;
    int coin_reject;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_txn(int m, int s, int r, int rv, int rj, int c);
    exp_t e;
    e.money = m; e.set = s; e.refund = r; e.refund_valid = rv; e.coin_reject = rj; e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: one line per observed output transaction
  always @(negedge clk) begin
    if (rst_n && (bus.set || bus.refund_valid || bus.coin_reject)) begin
      $display("txn cyc=%0d money=%0d set=%0b refund=%0d refund_valid=%0b coin_reject=%0b",
               cyc, bus.money, bus.set, bus.refund, bus.refund_valid, bus.coin_reject);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got set=%0b rv=%0b rej=%0b expected none",
                 bus.set, bus.refund_valid, bus.coin_reject);
      end else begin
        mon_e = sb.pop_front();
        check("money", int'(bus.money), mon_e.money);
        check("set", int'(bus.set), mon_e.set);
        check("refund", int'(bus.refund), mon_e.refund);
        check("refund_valid", int'(bus.refund_valid), mon_e.refund_valid);
        check("coin_reject", int'(bus.coin_reject), mon_e.coin_reject);
        if (mon_e.cyc >= 0) check("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic coin_at(bit c1, bit c5, bit c10, output int k);
    @(negedge clk);
    k = cyc;
    bus.coin1 = c1; bus.coin5 = c5; bus.coin10 = c10;
    repeat (2) @(negedge clk);
    bus.coin1 = 1'b0; bus.coin5 = 1'b0; bus.coin10 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic coin(bit c1, bit c5, bit c10);
    int k;
    coin_at(c1, c5, c10, k);
  endtask

  task automatic press(bit cf, bit cn);
    @(negedge clk);
    bus.confirm = cf; bus.cancel = cn;
    repeat (6) @(negedge clk);
    bus.confirm = 1'b0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_quiet(int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL wait_timeout: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(string tag);
    check({tag, "_state"}, int'(bus.state), 0);
    check({tag, "_pending"}, int'(bus.pending), 0);
  endtask

  initial begin
    int k;
    bus.coin1 = 1'b0; bus.coin5 = 1'b0; bus.coin10 = 1'b0;
    bus.confirm = 1'b0; bus.cancel = 1'b0; bus.remain = 10'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", int'(bus.state), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_money", int'(bus.money), 0);
    check("rst_set", int'(bus.set), 0);
    check("rst_refund", int'(bus.refund), 0);
    check("rst_refund_valid", int'(bus.refund_valid), 0);
    check("rst_coin_reject", int'(bus.coin_reject), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Buttons in IDLE are ignored
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check_idle("idle_buttons");

    // 1: 10+10+5+1, confirm, remain=0 -> money 26
    coin(0, 0, 1); coin(0, 0, 1); coin(0, 1, 0); coin(1, 0, 0);
    check("t1_pending", int'(bus.pending), 26);
    check("t1_state", int'(bus.state), 1);
    expect_txn(26, 1, 0, 0, 0, -1);
    press(1'b1, 1'b0);
    wait_quiet(50);
    check_idle("t1");

    // 2: 10+5 on same edge, cancel+confirm together -> refund 15
    coin(0, 1, 1);
    check("t2_pending", int'(bus.pending), 15);
    expect_txn(0, 0, 15, 1, 0, -1);
    press(1'b1, 1'b1);
    wait_quiet(50);
    check_idle("t2");

    // 3: build 495, coin10 rejected, coin5 reaches 500
    for (int i = 0; i < 49; i++) coin(0, 0, 1);
    coin(0, 1, 0);
    check("t3_pending_495", int'(bus.pending), 495);
    expect_txn(0, 0, 0, 0, 1, -1);
    coin(0, 0, 1);
    check("t3_pending_after_reject", int'(bus.pending), 495);
    coin(0, 1, 0);
    check("t3_pending_500", int'(bus.pending), 500);
    expect_txn(500, 1, 0, 0, 0, -1);
    press(1'b1, 1'b0);
    wait_quiet(50);
    check_idle("t3");

    // 4: pending 40, remain 1000 -> money 23, refund 17 together
    bus.remain = 10'd1000;
    for (int i = 0; i < 4; i++) coin(0, 0, 1);
    expect_txn(23, 1, 17, 1, 0, -1);
    press(1'b1, 1'b0);
    wait_quiet(50);
    bus.remain = 10'd0;
    check_idle("t4");

    // 5: timeout commit exactly T+2 cycles after the coin event (event at k+2)
    coin_at(0, 1, 0, k);
    expect_txn(5, 1, 0, 0, 0, k + 2 + T + 2);
    wait_quiet(T + 100);
    check_idle("t5a");
    coin_at(0, 1, 0, k);
    repeat (400) @(negedge clk);
    coin_at(1, 0, 0, k);
    expect_txn(6, 1, 0, 0, 0, k + 2 + T + 2);
    wait_quiet(T + 100);
    check_idle("t5b");

    // 6: bonus threshold at 50, not at 49
    for (int i = 0; i < 5; i++) coin(0, 0, 1);
`ifdef BONUS_CREDIT_EN
    expect_txn(55, 1, 0, 0, 0, -1);
`else
    expect_txn(50, 1, 0, 0, 0, -1);
`endif
    press(1'b1, 1'b0);
    wait_quiet(50);
    for (int i = 0; i < 4; i++) coin(0, 0, 1);
    coin(0, 1, 0);
    for (int i = 0; i < 4; i++) coin(1, 0, 0);
    check("t6_pending_49", int'(bus.pending), 49);
    expect_txn(49, 1, 0, 0, 0, -1);
    press(1'b1, 1'b0);
    wait_quiet(50);

    // Reset mid-COLLECT discards credit silently
    coin(0, 0, 1);
    check("t6_collect_state", int'(bus.state), 1);
    check("t6_collect_pending", int'(bus.pending), 10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pending", int'(bus.pending), 0);
    check("t6_rst_state", int'(bus.state), 0);
    check("t6_rst_refund_valid", int'(bus.refund_valid), 0);
    check("t6_rst_set", int'(bus.set), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_idle("t6_after_rst");

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coin_credit_acceptor.md
Name: coin_credit_acceptor

Overview:
- Payment front-end sitting directly upstream of the game time counter.
- Collects coin pulses of three denominations into a pending credit, then commits it as a one-cycle money/set pair on confirm or inactivity timeout.
- Refunds the pending credit on cancel.
- Clips each commit so the downstream 10-bit remaining-time register never overflows; the excess is returned as a refund.

Parameters:
- MAX_CREDIT, 500: upper limit of pending credit (units); must be ≤ 1023.
- TIMEOUT_CYC, 1000: idle cycles in COLLECT before auto-commit.
- DEB_CYC, 4: consecutive stable-high cycles required before a button press is accepted.
- BONUS_THRESH, 50: pending level that earns a bonus (BONUS_CREDIT_EN only).
- BONUS_AMT, 5: bonus units added at commit (BONUS_CREDIT_EN only).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- coin1, input, 1: raw asynchronous coin sensor, value 1.
- coin5, input, 1: raw asynchronous coin sensor, value 5.
- coin10, input, 1: raw asynchronous coin sensor, value 10.
- confirm, input, 1: raw asynchronous button; commits pending credit.
- cancel, input, 1: raw asynchronous button; refunds pending credit.
- remain, input, 10: current remaining time fed back from the downstream counter.
- money, output, 10: credit to add downstream; valid while set=1.
- set, output, 1: one-cycle commit strobe.
- refund, output, 10: amount to return; valid while refund_valid=1.
- refund_valid, output, 1: one-cycle refund strobe.
- pending, output, 10: current uncommitted credit.
- coin_reject, output, 1: one-cycle pulse when inserted coins are refused.
- state, output, 2: IDLE=0, COLLECT=1, COMMIT=2, REFUND=3.

Behaviour:
- Reset: clk is the clock; rst_n is the asynchronous, active-low reset. On reset, state=IDLE and money, set, refund, refund_valid, pending, coin_reject, timer and synchronizers are all 0.

Input conditioning:
- Every raw input passes through a 2-flop synchronizer.
- Coins: a rising edge of the synchronized signal yields a one-cycle coin event.
- Buttons: once the synchronized level is stable high for DEB_CYC cycles, emit one press pulse per press. Re-arm only after the level is seen low.

Coin summing:
- Events arriving in the same cycle are summed: sum = 1·c1 + 5·c5 + 10·c10.
- Accepted in IDLE and COLLECT only.
- If pending + sum > MAX_CREDIT, reject all of that cycle's coins: pending unchanged, coin_reject=1 next cycle.
- Coins arriving in COMMIT or REFUND are rejected the same way.

State machine:
- IDLE:
  - Accepted coin: pending ← sum, go to COLLECT, timer ← 0.
  - confirm and cancel are ignored.
- COLLECT:
  - Accepted coin: added to pending, timer ← 0.
  - Otherwise the timer increments.
  - cancel press → REFUND. Cancel wins over a simultaneous confirm.
  - confirm press, or timer == TIMEOUT_CYC−1 → COMMIT.
  - A coin in the same cycle as confirm or cancel is included in pending before the transition.
  - A rejected coin does not reset the timer.
- COMMIT (one cycle):
  - space = 1023 − remain, with remain sampled this cycle.
  - credit = pending.
  - If credit ≤ space: money ← credit, no refund.
  - Else: money ← space, and refund ← credit − space with refund_valid=1.
  - set=1 only when money > 0.
  - Then pending ← 0, go to IDLE.
- REFUND (one cycle): refund ← pending, refund_valid=1, pending ← 0, go to IDLE.

Timing and widths:
- All outputs are registered.
- set, money, refund and refund_valid are asserted in the cycle after the COMMIT/REFUND state cycle, for exactly one cycle. money and refund return to 0 otherwise.
- Latency: the press pulse in cycle N moves state to COMMIT in N+1 and asserts set in N+2.
- Arithmetic uses 11-bit intermediates; there is no wrap-around anywhere.
- Reset mid-transaction discards pending credit with no refund strobe.

Optional Feature:
- Macro: BONUS_CREDIT_EN.
- Defined: in COMMIT, credit = pending + BONUS_AMT when pending ≥ BONUS_THRESH, else pending. money = min(credit, space). refund = max(0, pending − space); bonus is never refunded.
- Undefined: no bonus logic, and BONUS_THRESH and BONUS_AMT are unused.

Test Plan:
1. Reset, then coins 10, 10, 5, 1 (spaced), confirm held 6 cycles, remain=0 → set=1 one cycle, money=26, no refund, pending=0, state back to IDLE.
2. Coins 10+5 on the same edge, then cancel and confirm pressed together → refund_valid=1, refund=15, set stays 0.
3. pending=495, coin10 inserted → coin_reject=1 one cycle, pending stays 495. Then coin5 → pending=500.
4. pending=40, remain=1000, confirm → money=23, set=1, refund=17, refund_valid=1 in the same cycle.
5. Single coin5, no buttons → set=1, money=5 exactly TIMEOUT_CYC+2 cycles after the coin event. A coin inserted before timeout restarts the count.
6. BONUS_CREDIT_EN defined, pending=50, remain=0, confirm → money=55. With pending=49 → money=49. Also assert rst_n mid-COLLECT → pending=0 with no strobes.
